// File: rtl/seq_mult_shift_add.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned per operation.
// Works on operand magnitudes and applies the sign once, when the product is loaded into p.
module seq_mult_shift_add #(
  parameter int WIDTH      = 4,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] full_nxt;
  logic [WIDTH-1:0]   rem_mask;
  logic [CW-1:0]      sh;
  logic               last;

  // The most negative value maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    magnitude = (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m, input logic n);
    apply_sign = n ? (~m + 1'b1) : m;
  endfunction

  // {acc, mplier} after this iteration, top bit dropped (always zero). Low bits of the
  // multiplier register not yet consumed are the remaining multiplier bits.
  always_comb begin
    sum      = acc + (mplier[0] ? {1'b0, mcand} : '0);
    full_nxt = {sum, mplier[WIDTH-1:1]};
    rem_mask = {WIDTH{1'b1}} >> (cnt + 1'b1);
    sh       = CW'(WIDTH - 1) - cnt;
    last     = (cnt == CW'(WIDTH - 1)) ||
               (EARLY_EXIT && ((full_nxt[WIDTH-1:0] & rem_mask) == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      p         <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= magnitude(a, signed_mode);
            mplier   <= magnitude(b, signed_mode);
            neg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc    <= {1'b0, sum[WIDTH:1]};
          mplier <= full_nxt[WIDTH-1:0];
          cnt    <= cnt + 1'b1;
          if (last) begin
            // Shifting by the unused iteration count realigns an early-terminated product.
            p         <= apply_sign(full_nxt >> sh, neg);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add: a WIDTH=4 full-latency instance and a WIDTH=8
// early-exit instance, driven and sampled on the falling clock edge.
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid4 = 1'b0, in_ready4, sm4 = 1'b0, out_valid4, out_ready4 = 1'b0, busy4;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;
  logic       in_valid8 = 1'b0, in_ready8, sm8 = 1'b0, out_valid8, out_ready8 = 1'b0, busy8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult_shift_add #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .signed_mode(sm4), .out_valid(out_valid4), .out_ready(out_ready4), .p(p4), .busy(busy4)
  );

  seq_mult_shift_add #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .signed_mode(sm8), .out_valid(out_valid8), .out_ready(out_ready8), .p(p8), .busy(busy8)
  );

  // Drivers only: present operands for one edge, return at the falling edge after accept.
  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic sm);
    a4 = a; b4 = b; sm4 = sm; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
  endtask

  task automatic wait4(output int cyc);
    cyc = 0;
    while (out_valid4 !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    a8 = a; b8 = b; sm8 = sm; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic wait8(output int cyc);
    cyc = 0;
    while (out_valid8 !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (in_ready4 !== 1'b1) begin $display("FAIL rst_in_ready4 got=%b want=1", in_ready4); n_bad++; end
    n_cmp++; if (out_valid4 !== 1'b0) begin $display("FAIL rst_out_valid4 got=%b want=0", out_valid4); n_bad++; end
    n_cmp++; if (busy4 !== 1'b0) begin $display("FAIL rst_busy4 got=%b want=0", busy4); n_bad++; end
    n_cmp++; if (p4 !== 8'h00) begin $display("FAIL rst_p4 got=%h want=00", p4); n_bad++; end
    n_cmp++; if (in_ready8 !== 1'b1) begin $display("FAIL rst_in_ready8 got=%b want=1", in_ready8); n_bad++; end
    n_cmp++; if (out_valid8 !== 1'b0) begin $display("FAIL rst_out_valid8 got=%b want=0", out_valid8); n_bad++; end
    n_cmp++; if (p8 !== 16'h0000) begin $display("FAIL rst_p8 got=%h want=0000", p8); n_bad++; end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int cyc;
    start4(4'd15, 4'd14, 1'b0);
    n_cmp++; if (in_ready4 !== 1'b0) begin $display("FAIL u_in_ready_busy got=%b want=0", in_ready4); n_bad++; end
    n_cmp++; if (busy4 !== 1'b1) begin $display("FAIL u_busy got=%b want=1", busy4); n_bad++; end
    wait4(cyc);
    n_cmp++; if (cyc !== 4) begin $display("FAIL u_latency got=%0d want=4", cyc); n_bad++; end
    n_cmp++; if (p4 !== 8'hD2) begin $display("FAIL u_15x14 got=%h want=d2", p4); n_bad++; end
    n_cmp++; if (busy4 !== 1'b1) begin $display("FAIL u_busy_done got=%b want=1", busy4); n_bad++; end
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    n_cmp++; if (out_valid4 !== 1'b0) begin $display("FAIL u_out_valid_drop got=%b want=0", out_valid4); n_bad++; end
    n_cmp++; if (in_ready4 !== 1'b1 || busy4 !== 1'b0) begin $display("FAIL u_idle got=%b%b want=10", in_ready4, busy4); n_bad++; end
    n_cmp++; if (p4 !== 8'hD2) begin $display("FAIL u_p_hold got=%h want=d2", p4); n_bad++; end
  endtask

  task automatic test_back_to_back();
    logic [3:0] av[4] = '{4'd10, 4'd12, 4'd7, 4'd9};
    logic [3:0] bv[4] = '{4'd11, 4'd13, 4'd8, 4'd10};
    logic [7:0] pv[4] = '{8'd110, 8'd156, 8'd56, 8'd90};
    int cyc;
    out_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start4(av[i], bv[i], 1'b0);
      n_cmp++; if (in_ready4 !== 1'b0) begin $display("FAIL b2b_in_ready_busy[%0d] got=%b want=0", i, in_ready4); n_bad++; end
      wait4(cyc);
      n_cmp++; if (cyc !== 4) begin $display("FAIL b2b_latency[%0d] got=%0d want=4", i, cyc); n_bad++; end
      n_cmp++; if (p4 !== pv[i]) begin $display("FAIL b2b_p[%0d] got=%0d want=%0d", i, p4, pv[i]); n_bad++; end
      n_cmp++; if (in_ready4 !== 1'b0) begin $display("FAIL b2b_in_ready_done[%0d] got=%b want=0", i, in_ready4); n_bad++; end
      @(negedge clk);
      n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin $display("FAIL b2b_handshake[%0d] got=%b%b want=01", i, out_valid4, in_ready4); n_bad++; end
    end
    out_ready4 = 1'b0;
  endtask

  task automatic test_signed();
    logic [3:0] av[3] = '{4'hF, 4'h8, 4'h7};
    logic [3:0] bv[3] = '{4'hE, 4'h8, 4'h8};
    logic [7:0] pv[3] = '{8'h02, 8'h40, 8'hC8};
    int cyc;
    out_ready4 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start4(av[i], bv[i], 1'b1);
      wait4(cyc);
      n_cmp++; if (cyc !== 4) begin $display("FAIL s_latency[%0d] got=%0d want=4", i, cyc); n_bad++; end
      n_cmp++; if (p4 !== pv[i]) begin $display("FAIL s_p[%0d] got=%h want=%h", i, p4, pv[i]); n_bad++; end
      @(negedge clk);
    end
    out_ready4 = 1'b0;
  endtask

  task automatic test_backpressure();
    int cyc;
    start4(4'd9, 4'd10, 1'b0);
    wait4(cyc);
    n_cmp++; if (p4 !== 8'd90) begin $display("FAIL bp_p got=%0d want=90", p4); n_bad++; end
    for (int i = 0; i < 10; i++) begin
      in_valid4 = 1'b1; a4 = 4'(i); b4 = 4'd3;
      @(negedge clk);
      n_cmp++; if (out_valid4 !== 1'b1 || p4 !== 8'd90 || in_ready4 !== 1'b0) begin
        $display("FAIL bp_hold[%0d] got ov=%b p=%0d ir=%b want ov=1 p=90 ir=0", i, out_valid4, p4, in_ready4); n_bad++; end
    end
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin $display("FAIL bp_release got=%b%b want=01", out_valid4, in_ready4); n_bad++; end
    n_cmp++; if (p4 !== 8'd90) begin $display("FAIL bp_p_after got=%0d want=90", p4); n_bad++; end
  endtask

  task automatic test_reset_midop();
    int cyc;
    start4(4'd15, 4'd15, 1'b0);
    @(negedge clk);
    n_cmp++; if (busy4 !== 1'b1) begin $display("FAIL rm_busy_before got=%b want=1", busy4); n_bad++; end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || busy4 !== 1'b0) begin
      $display("FAIL rm_ctrl got ov=%b ir=%b busy=%b want 0 1 0", out_valid4, in_ready4, busy4); n_bad++; end
    n_cmp++; if (p4 !== 8'h00) begin $display("FAIL rm_p got=%h want=00", p4); n_bad++; end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid4 !== 1'b0) begin $display("FAIL rm_no_partial got=%b want=0", out_valid4); n_bad++; end
    start4(4'd3, 4'd5, 1'b0);
    wait4(cyc);
    n_cmp++; if (cyc !== 4) begin $display("FAIL rm_latency got=%0d want=4", cyc); n_bad++; end
    n_cmp++; if (p4 !== 8'd15) begin $display("FAIL rm_3x5 got=%0d want=15", p4); n_bad++; end
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
  endtask

  task automatic test_early_exit();
    logic [7:0]  av[4] = '{8'd255, 8'd200, 8'd37, 8'hFD};
    logic [7:0]  bv[4] = '{8'd255, 8'd1,   8'd0,  8'd6};
    logic        sv[4] = '{1'b0,   1'b0,   1'b0,  1'b1};
    logic [15:0] pv[4] = '{16'hFE01, 16'd200, 16'd0, 16'hFFEE};
    int          lv[4] = '{8, 1, 1, 3};
    int cyc;
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start8(av[i], bv[i], sv[i]);
      wait8(cyc);
      n_cmp++; if (cyc !== lv[i]) begin $display("FAIL ee_latency[%0d] got=%0d want=%0d", i, cyc, lv[i]); n_bad++; end
      n_cmp++; if (p8 !== pv[i]) begin $display("FAIL ee_p[%0d] got=%h want=%h", i, p8, pv[i]); n_bad++; end
      @(negedge clk);
      n_cmp++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin $display("FAIL ee_handshake[%0d] got=%b%b want=01", i, out_valid8, in_ready8); n_bad++; end
    end
    out_ready8 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_back_to_back();
    test_signed();
    test_backpressure();
    test_reset_midop();
    test_early_exit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
